// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback control around an external ROM and decoder.
// dbg_state exposes the FSM state: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEM, 5 WRITEBACK, 6 HALTED.
module core_sequencer #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            step,
   input  logic [23:0]     rom_rdata,
   input  logic            dec_halt,
   input  logic            dec_is_load,
   input  logic            dec_write_en,
   input  logic            dec_ram_write_en,
   input  logic            dec_pc_overwrite,
   input  logic [7:0]      dec_imm,
   output logic [PC_W-1:0] rom_addr,
   output logic [23:0]     ir,
   output logic            rf_we,
   output logic            ram_we,
   output logic            halted,
   output logic            busy,
   output logic [15:0]     retired,
   output logic [2:0]      dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALTED    = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [23:0]     ir_q, ir_d;
   logic [15:0]     retired_q, retired_d;
   logic [PC_W-1:0] imm_pc;

   // Jump target: the 8-bit immediate fitted to the program counter width.
   generate
      if (PC_W == 8) begin : g_imm_eq
         assign imm_pc = dec_imm;
      end else if (PC_W > 8) begin : g_imm_ext
         assign imm_pc = {{(PC_W-8){1'b0}}, dec_imm};
      end else begin : g_imm_trunc
         assign imm_pc = dec_imm[PC_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      rf_we     = 1'b0;
      ram_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run || step) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = rom_rdata;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            // A HALT retires on entry to HALTED, since it never reaches writeback.
            if (dec_halt) begin
               state_d   = S_HALTED;
               retired_d = retired_q + 16'd1;
            end else if (dec_is_load) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEM: state_d = S_WRITEBACK;
         S_WRITEBACK: begin
            rf_we     = dec_write_en;
            ram_we    = dec_ram_write_en;
            retired_d = retired_q + 16'd1;
            pc_d      = dec_pc_overwrite ? imm_pc : pc_q + PC_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   assign rom_addr  = pc_q;
   assign ir        = ir_q;
   assign retired   = retired_q;
   assign halted    = (state_q == S_HALTED);
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a registered instruction ROM and a small opcode decoder model.
module tb_core_sequencer;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXECUTE = 3'd3,
                          ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALTED = 3'd6;
   localparam logic [23:0] I_ADD = 24'h012345, I_LOAD = 24'h100011, I_STORE = 24'h200022,
                           I_HALT = 24'hF0ABCD;

   logic        clk = 1'b0;
   logic        rst, run, step;
   logic [23:0] rom_rdata;
   logic        dec_halt, dec_is_load, dec_write_en, dec_ram_write_en, dec_pc_overwrite;
   logic [7:0]  dec_imm;
   logic [7:0]  rom_addr;
   logic [23:0] ir;
   logic        rf_we, ram_we, halted, busy;
   logic [15:0] retired;
   logic [2:0]  dbg_state;

   logic [23:0] rom [256];
   int tests = 0;
   int fails = 0;

   core_sequencer #(.PC_W(8)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .rom_rdata(rom_rdata),
      .dec_halt(dec_halt), .dec_is_load(dec_is_load), .dec_write_en(dec_write_en),
      .dec_ram_write_en(dec_ram_write_en), .dec_pc_overwrite(dec_pc_overwrite),
      .dec_imm(dec_imm), .rom_addr(rom_addr), .ir(ir), .rf_we(rf_we), .ram_we(ram_we),
      .halted(halted), .busy(busy), .retired(retired), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_rdata <= rom[rom_addr];

   // Opcode in ir[23:20]: 0 ADD, 1 LOAD, 2 STORE, E JUMP to ir[7:0], F HALT.
   assign dec_halt         = (ir[23:20] == 4'hF);
   assign dec_is_load      = (ir[23:20] == 4'h1);
   assign dec_write_en     = (ir[23:20] == 4'h0) || (ir[23:20] == 4'h1);
   assign dec_ram_write_en = (ir[23:20] == 4'h2);
   assign dec_pc_overwrite = (ir[23:20] == 4'hE);
   assign dec_imm          = ir[7:0];

   function automatic logic [23:0] jmp(input logic [7:0] tgt);
      return {16'hE000, tgt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse step from IDLE; report busy cycles until IDLE and whether each strobe was seen.
   task automatic do_step(output int cycles, output logic saw_rf, output logic saw_ram);
      int n;
      step = 1'b1;
      tick();
      step = 1'b0;
      n = 1;
      saw_rf = 1'b0;
      saw_ram = 1'b0;
      while (dbg_state != ST_IDLE && n < 12) begin
         saw_rf  = saw_rf | rf_we;
         saw_ram = saw_ram | ram_we;
         tick();
         n++;
      end
      cycles = n - 1;
   endtask

   initial begin
      int cyc;
      logic srf, sram;
      logic found;
      rst = 1'b0;
      run = 1'b0;
      step = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = I_HALT;

      // ADD then HALT under run
      rom[0] = I_ADD;
      rom[1] = I_HALT;
      tick();
      tick();
      check("reset_state", {dbg_state, rom_addr, retired, ir}, {ST_IDLE, 8'h00, 16'h0, 24'h0});
      check("reset_flags", {rf_we, ram_we, halted, busy}, 4'b0000);
      rst = 1'b1;
      tick();
      tick();
      check("idle_after_reset", dbg_state, ST_IDLE);
      run = 1'b1;
      tick();
      check("c1_fetch", {dbg_state, rom_addr, busy}, {ST_FETCH, 8'h00, 1'b1});
      tick();
      check("c2_decode", dbg_state, ST_DECODE);
      tick();
      check("c3_execute", {dbg_state, ir, rf_we}, {ST_EXECUTE, I_ADD, 1'b0});
      tick();
      check("c4_wb_strobe", {dbg_state, rf_we, ram_we}, {ST_WB, 1'b1, 1'b0});
      tick();
      check("c5_fetch", {dbg_state, rom_addr, retired}, {ST_FETCH, 8'h01, 16'd1});
      tick();
      tick();
      check("c7_execute_halt", {dbg_state, ir}, {ST_EXECUTE, I_HALT});
      tick();
      check("c8_halted", {dbg_state, halted, busy, retired, rom_addr}, {ST_HALTED, 1'b1, 1'b0, 16'd2, 8'h01});

      // HALTED is sticky against run and step
      for (int i = 0; i < 20; i++) begin
         step = i[0];
         tick();
         check("halt_sticky", {dbg_state, rom_addr, retired, ir, rf_we, ram_we, halted},
               {ST_HALTED, 8'h01, 16'd2, I_HALT, 2'b00, 1'b1});
      end
      step = 1'b0;

      // Load at pc=3, then reset during the next load's MEM cycle
      rst = 1'b0;
      rom[0] = I_ADD;
      rom[1] = I_ADD;
      rom[2] = I_ADD;
      rom[3] = I_LOAD;
      rom[4] = I_LOAD;
      tick();
      check("reset_from_halted", {dbg_state, halted, retired}, {ST_IDLE, 1'b0, 16'd0});
      rst = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (dbg_state == ST_FETCH && rom_addr == 8'h03) found = 1'b1;
      end
      check("reach_pc3", found, 1'b1);
      check("retired_at_pc3", retired, 16'd3);
      tick();
      tick();
      check("load_execute", {dbg_state, rf_we}, {ST_EXECUTE, 1'b0});
      tick();
      check("load_mem", {dbg_state, rf_we, ram_we}, {ST_MEM, 2'b00});
      tick();
      check("load_wb_c5", {dbg_state, rf_we}, {ST_WB, 1'b1});
      tick();
      check("after_load", {dbg_state, rom_addr, retired}, {ST_FETCH, 8'h04, 16'd4});
      tick();
      tick();
      tick();
      check("second_load_mem", dbg_state, ST_MEM);
      rst = 1'b0;
      #1;
      check("mid_mem_reset", {dbg_state, rom_addr, retired, ir}, {ST_IDLE, 8'h00, 16'd0, 24'h0});
      check("mid_mem_reset_flags", {rf_we, ram_we, halted, busy}, 4'b0000);
      tick();
      check("held_in_reset", dbg_state, ST_IDLE);
      rst = 1'b1;
      tick();
      check("restart_fetch", {dbg_state, rom_addr}, {ST_FETCH, 8'h00});
      run = 1'b0;
      tick();
      tick();
      tick();
      check("finish_after_run_low", {dbg_state, rf_we}, {ST_WB, 1'b1});
      tick();
      check("idle_after_run_low", {dbg_state, rom_addr, retired}, {ST_IDLE, 8'h01, 16'd1});

      // Single step, with an ignored second step during EXECUTE
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_fetch", {dbg_state, rom_addr}, {ST_FETCH, 8'h01});
      tick();
      tick();
      check("step_execute", dbg_state, ST_EXECUTE);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_wb", {dbg_state, rf_we}, {ST_WB, 1'b1});
      tick();
      check("step_done", {dbg_state, rom_addr, retired}, {ST_IDLE, 8'h02, 16'd2});
      tick();
      tick();
      check("step_not_queued", {dbg_state, rom_addr, retired}, {ST_IDLE, 8'h02, 16'd2});

      // Jumps and wrap at pc=0xFF, store and load via step
      rst = 1'b0;
      rom[0] = jmp(8'hFF);
      rom[255] = jmp(8'h20);
      tick();
      rst = 1'b1;
      tick();
      do_step(cyc, srf, sram);
      check("jump_to_ff", {rom_addr, srf, sram}, {8'hFF, 2'b00});
      check("step_latency", cyc, 4);
      do_step(cyc, srf, sram);
      check("jump_from_ff", rom_addr, 8'h20);
      rom[32] = jmp(8'hFF);
      do_step(cyc, srf, sram);
      check("jump_back_ff", rom_addr, 8'hFF);
      rom[255] = I_ADD;
      do_step(cyc, srf, sram);
      check("pc_wrap", {rom_addr, srf, sram}, {8'h00, 2'b10});
      rom[0] = I_STORE;
      do_step(cyc, srf, sram);
      check("store_strobe", {rom_addr, srf, sram}, {8'h01, 2'b01});
      rom[1] = I_LOAD;
      do_step(cyc, srf, sram);
      check("step_load_latency", {cyc[7:0], rom_addr, srf}, {8'd5, 8'h02, 1'b1});
      check("retired_steps", {dbg_state, retired}, {ST_IDLE, 16'd6});

      // run and step together behave as run
      rom[2] = I_ADD;
      run = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("run_and_step", {dbg_state, rom_addr, retired}, {ST_FETCH, 8'h03, 16'd7});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter PC_W, default 8: width of program counter and instruction ROM address.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; high = execute instructions continuously.
REQ-005 step  input  1  one-cycle pulse; executes exactly one instruction when idle and run low.
REQ-006 rom_rdata  input  24  instruction ROM data, valid the cycle after rom_addr is presented.
REQ-007 dec_halt, dec_is_load, dec_write_en, dec_ram_write_en, dec_pc_overwrite  input  1 each  decoder outputs, combinational from ir.
REQ-008 dec_imm  input  8  decoder immediate, used as jump target.
REQ-009 rom_addr  output  PC_W  instruction fetch address, equals pc.
REQ-010 ir  output  24  latched instruction driving the decoder.
REQ-011 rf_we  output  1  register-file write strobe.
REQ-012 ram_we  output  1  data RAM write strobe.
REQ-013 halted  output  1  core stopped on HALT.
REQ-014 busy  output  1  high in every state except IDLE and HALTED.
REQ-015 retired  output  16  count of completed instructions.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED.
REQ-017 IDLE -> FETCH when run=1 or step=1; run and step both high SHALL be treated as run.
REQ-018 FETCH: rom_addr=pc presented; next state DECODE unconditionally.
REQ-019 DECODE: ir SHALL load rom_rdata at the end of the cycle; next state EXECUTE.
REQ-020 EXECUTE: decoder/ALU settle from stable ir; next = HALTED if dec_halt, else MEM if dec_is_load, else WRITEBACK.
REQ-021 MEM: one cycle for synchronous RAM read; next state WRITEBACK.
REQ-022 WRITEBACK: rf_we=dec_write_en and ram_we=dec_ram_write_en for exactly this one cycle; rf_we and ram_we SHALL be 0 in all other states.
REQ-023 WRITEBACK pc update: pc <= dec_imm[PC_W-1:0] (zero-extended if PC_W>8) when dec_pc_overwrite=1, else pc+1 modulo 2^PC_W (max value wraps to 0).
REQ-024 WRITEBACK exit: FETCH if run=1, else IDLE; deasserting run mid-instruction SHALL complete the current instruction first.
REQ-025 retired SHALL increment by 1 in each WRITEBACK and on entry to HALTED, wrapping 0xFFFF -> 0x0000.
REQ-026 Latency: non-load instruction 4 cycles FETCH-to-FETCH; load 5 cycles; step from IDLE returns to IDLE after 4 or 5 cycles.
REQ-027 HALTED SHALL be sticky: pc not advanced, no strobes, run and step ignored, halted=1; only rst exits it.
REQ-028 step pulses arriving outside IDLE SHALL be ignored, not queued.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, pc=0, ir=0, retired=0, rf_we=0, ram_we=0, halted=0, busy=0, including mid-instruction.
REQ-030 After rst rises, the FSM SHALL stay in IDLE until run or step is sampled high.

Verification
REQ-031 run=1, ROM: 0x0 ADD then F HALT -> FETCH at cycles 1 and 5, rf_we pulse in cycle 4, halted=1 from cycle 8, retired=2, pc=1.
REQ-032 Load at pc=3 with run=1 -> EXECUTE->MEM->WRITEBACK, rf_we in the 5th cycle, pc=4.
REQ-033 Jump E with dec_imm=0x20 at pc=0xFF -> pc=0x20; non-jump at pc=0xFF -> pc=0x00.
REQ-034 run=0, step pulse in IDLE -> one instruction, retired +1, back in IDLE; second step pulse during EXECUTE -> no effect.
REQ-035 rst asserted low during MEM -> same-cycle outputs reset: pc=0, retired=0, rf_we=0, state IDLE; with run held high, FETCH restarts the cycle after rst rises.
REQ-036 HALTED with run=1 and step pulses for 20 cycles -> pc, retired, and ir unchanged; rf_we=ram_we=0.
